// File: rtl/text_render_pkg.sv
// rtl/text_render_pkg.sv - shared widths, palette and side-band types for the text pixel renderer
package text_render_pkg;

    localparam int RGB_W      = 12;
    localparam int ROM_ADDR_W = 11;
    localparam int FONT_W     = 8;
    localparam int PIPE_LAT   = 3;

    localparam logic [3:0] COL_BLACK  = 4'd0;
    localparam logic [3:0] COL_WHITE  = 4'd2;
    localparam logic [3:0] COL_YELLOW = 4'd3;
    localparam logic [3:0] COL_RED    = 4'd4;
    localparam logic [3:0] COL_BLINK  = 4'd15;

    // Colour shown by COL_BLINK during the "on" half of the blink period.
    localparam logic [RGB_W-1:0] BLINK_ON_COLOR = 12'hFFF;

    // font_size encoding that selects 2x horizontal scaling; every other code is 8x16.
    localparam logic [1:0] FS_2X = 2'd2;

    // Entry 15 is overridden at run time by the blink logic.
    localparam logic [RGB_W-1:0] PALETTE [16] = '{
        12'h000, 12'h00F, 12'hFFF, 12'hFF0,
        12'hF00, 12'h0F0, 12'h0FF, 12'hF0F,
        12'h888, 12'hF80, 12'h8F0, 12'h08F,
        12'hF08, 12'h444, 12'hCCC, 12'hFFF
    };

    // Per-pixel information that travels alongside the font ROM access.
    typedef struct packed {
        logic       video_on;
        logic       hsync;
        logic       vsync;
        logic       dp;
        logic [3:0] color;
        logic [2:0] col;
    } side_t;

    // Idle side-band: blanked, syncs at their inactive (high) level.
    localparam side_t SIDE_RESET = '{
        video_on: 1'b0, hsync: 1'b1, vsync: 1'b1,
        dp: 1'b0, color: 4'd0, col: 3'd0
    };

    // Glyph column within the 8-bit font row; 2x mode halves the column rate.
    function automatic logic [2:0] font_col(input logic [3:0] x_lo, input logic [1:0] fs);
        return (fs == FS_2X) ? x_lo[3:1] : x_lo[2:0];
    endfunction

endpackage

// File: rtl/frame_blink_counter.sv
// rtl/frame_blink_counter.sv - counts vsync falling edges and produces the blink phase
module frame_blink_counter #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic vsync_in,
    output logic blink_phase
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(BLINK_FRAMES - 1);

    logic             vsync_q;
    logic [CNT_W-1:0] frame_cnt;
    logic             vsync_fall;

    assign vsync_fall = vsync_q & ~vsync_in;

    // Edge detect and frame count; vsync_q tracks the input during reset so a
    // low vsync at release does not look like a fresh frame boundary.
    always_ff @(posedge clk) begin
        vsync_q <= vsync_in;
        if (reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (vsync_fall) begin
            if (frame_cnt == LAST_FRAME) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/text_pixel_renderer.sv
// rtl/text_pixel_renderer.sv - font ROM fetch, pixel select and palette lookup with aligned syncs
module text_pixel_renderer
    import text_render_pkg::*;
#(
    parameter logic [RGB_W-1:0] BG_COLOR     = 12'h000,
    parameter int               BLINK_FRAMES = 30
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  video_on,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic [9:0]            pixelx,
    input  logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [1:0]            font_size,
    input  logic [3:0]            color_addr,
    input  logic                  dp,
    output logic [ROM_ADDR_W-1:0] font_rom_addr,
    input  logic [FONT_W-1:0]     font_rom_data,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic [RGB_W-1:0]      rgb
);

    side_t            side_s1;
    side_t            side_s2;
    logic             blink_phase;
    logic             font_bit;
    logic [RGB_W-1:0] lit_color;
    logic             unused_pixelx_hi;

    // Only the low column bits matter for glyph addressing.
    assign unused_pixelx_hi = ^pixelx[9:4];

    frame_blink_counter #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk         (clk),
        .reset       (reset),
        .vsync_in    (vsync_in),
        .blink_phase (blink_phase)
    );

    // Stage 1: launch the ROM read and capture the pixel's side-band.
    always_ff @(posedge clk) begin
        if (reset) begin
            font_rom_addr <= '0;
            side_s1       <= SIDE_RESET;
        end else begin
            font_rom_addr    <= rom_addr;
            side_s1.video_on <= video_on;
            side_s1.hsync    <= hsync_in;
            side_s1.vsync    <= vsync_in;
            side_s1.dp       <= dp;
            side_s1.color    <= color_addr;
            side_s1.col      <= font_col(pixelx[3:0], font_size);
        end
    end

    // Stage 2: side-band waits one clock while the ROM produces its row.
    always_ff @(posedge clk) begin
        if (reset) begin
            side_s2 <= SIDE_RESET;
        end else begin
            side_s2 <= side_s1;
        end
    end

    // Bit 7 of the font row is the leftmost glyph column.
    assign font_bit = font_rom_data[3'd7 - side_s2.col];

    // Palette lookup with the blink entry resolved against the current phase.
    always_comb begin
        lit_color = PALETTE[side_s2.color];
        if (side_s2.color == COL_BLINK) begin
            lit_color = blink_phase ? BLINK_ON_COLOR : BG_COLOR;
        end
    end

    // Stage 3: registered colour and syncs leave together.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb       <= '0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            hsync_out <= side_s2.hsync;
            vsync_out <= side_s2.vsync;
            if (!side_s2.video_on) begin
                rgb <= '0;
            end else if (side_s2.dp && font_bit) begin
                rgb <= lit_color;
            end else begin
                rgb <= BG_COLOR;
            end
        end
    end

endmodule

// File: tb/tb_text_pixel_renderer.sv
// tb/tb_text_pixel_renderer.sv - scoreboard bench for text_pixel_renderer
module tb_text_pixel_renderer;
    import text_render_pkg::*;

    localparam logic [11:0] BG = 12'h035;

    logic        clk;
    logic        reset;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;
    logic [9:0]  pixelx;
    logic [10:0] rom_addr;
    logic [1:0]  font_size;
    logic [3:0]  color_addr;
    logic        dp;
    logic [10:0] font_rom_addr;
    logic [7:0]  font_rom_data;
    logic        hsync_out;
    logic        vsync_out;
    logic [11:0] rgb;

    text_pixel_renderer #(
        .BG_COLOR     (BG),
        .BLINK_FRAMES (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .video_on      (video_on),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .pixelx        (pixelx),
        .rom_addr      (rom_addr),
        .font_size     (font_size),
        .color_addr    (color_addr),
        .dp            (dp),
        .font_rom_addr (font_rom_addr),
        .font_rom_data (font_rom_data),
        .hsync_out     (hsync_out),
        .vsync_out     (vsync_out),
        .rgb           (rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        case (font_rom_addr)
            11'h301: font_rom_data <= 8'b1000_0001;
            11'h0A3: font_rom_data <= 8'b1100_0100;
            11'h155: font_rom_data <= 8'b1111_1111;
            default: font_rom_data <= 8'h00;
        endcase
    end

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic drv_chk = 1'b0;

    task automatic pix(input logic von, input logic hs, input logic vs, input logic [9:0] x,
                       input logic [10:0] addr, input logic [1:0] fs, input logic [3:0] col,
                       input logic d, input logic [11:0] er, input string nm);
        exp_t e;
        video_on = von; hsync_in = hs; vsync_in = vs; pixelx = x;
        rom_addr = addr; font_size = fs; color_addr = col; dp = d;
        drv_chk = 1'b1;
        e.rgb = er; e.hs = hs; e.vs = vs; e.name = nm;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; dp = 1'b0;
            drv_chk = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic vpulse();
        pix(1'b0, 1'b1, 1'b0, 10'd0, 11'h000, 2'd1, 4'd0, 1'b0, 12'h000, "vsync_low");
        pix(1'b0, 1'b1, 1'b0, 10'd0, 11'h000, 2'd1, 4'd0, 1'b0, 12'h000, "vsync_low");
        idle(1);
    endtask

    task automatic blink_frame(input logic [11:0] er, input string nm);
        pix(1'b1, 1'b1, 1'b1, 10'd0, 11'h301, 2'd1, COL_BLINK, 1'b1, er, nm);
        idle(3);
        vpulse();
    endtask

    task automatic pulse_reset(input int n);
        reset = 1'b1;
        drv_chk = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: tracks which output cycles carry a scored pixel and checks them.
    initial begin : monitor
        logic [2:0] f;
        int         since_rst;
        exp_t       e;
        f = 3'b000;
        since_rst = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                if (f[0]) e = exp_q.pop_back();
                if (f[1]) e = exp_q.pop_back();
                f = 3'b000;
                since_rst = 0;
            end else begin
                f = {f[1:0], drv_chk};
                if (since_rst < 3) since_rst++;
            end
            @(negedge clk);
            if (since_rst <= 2) begin
                n_vec++;
                if (rgb !== 12'h000 || hsync_out !== 1'b1 || vsync_out !== 1'b1 ||
                    (since_rst == 0 && font_rom_addr !== 11'h000)) begin
                    n_bad++;
                    $display("FAIL reset_state(+%0d): rgb=%h hs=%b vs=%b addr=%h, expected rgb=000 hs=1 vs=1 addr=000",
                             since_rst, rgb, hsync_out, vsync_out, font_rom_addr);
                end
            end else if (f[2]) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL queue_underflow: output rgb=%h with no expectation, expected a queued pixel", rgb);
                end else begin
                    e = exp_q.pop_front();
                    if (rgb !== e.rgb || hsync_out !== e.hs || vsync_out !== e.vs) begin
                        n_bad++;
                        $display("FAIL %s: rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                                 e.name, rgb, hsync_out, vsync_out, e.rgb, e.hs, e.vs);
                    end
                end
            end
        end
    end

    initial begin : driver
        reset = 1'b1;
        video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; pixelx = '0;
        rom_addr = '0; font_size = 2'd1; color_addr = '0; dp = 1'b0;

        for (int i = 0; i < 5; i++) begin
            video_on   = 1'($urandom);
            hsync_in   = 1'($urandom);
            vsync_in   = 1'($urandom);
            pixelx     = 10'($urandom);
            rom_addr   = 11'($urandom);
            font_size  = 2'($urandom);
            color_addr = 4'($urandom);
            dp         = 1'($urandom);
            @(negedge clk);
        end
        reset = 1'b0;

        for (int x = 0; x < 8; x++)
            pix(1'b1, (x == 3) ? 1'b0 : 1'b1, 1'b1, 10'(x), 11'h301, 2'd1, COL_WHITE, 1'b1,
                (x == 0 || x == 7) ? 12'hFFF : BG, "bit_order_81");
        for (int x = 0; x < 8; x++)
            pix(1'b1, 1'b1, 1'b1, 10'(x), 11'h0A3, 2'd1, COL_WHITE, 1'b1,
                (x == 0 || x == 1 || x == 5) ? 12'hFFF : BG, "bit_order_c4");
        for (int x = 0; x < 16; x++)
            pix(1'b1, 1'b1, 1'b1, 10'(x), 11'h301, 2'd2, COL_WHITE, 1'b1,
                (x <= 1 || x >= 14) ? 12'hFFF : BG, "scale2x_81");
        for (int x = 0; x < 16; x++)
            pix(1'b1, 1'b1, 1'b1, 10'(x), 11'h0A3, 2'd2, COL_WHITE, 1'b1,
                (x <= 3 || x == 10 || x == 11) ? 12'hFFF : BG, "scale2x_c4");
        for (int x = 0; x < 8; x++)
            pix(1'b1, 1'b1, 1'b1, 10'(16 + x), 11'h301, 2'd0, COL_WHITE, 1'b1,
                (x == 0 || x == 7) ? 12'hFFF : BG, "fs0_as_1");
        for (int x = 0; x < 8; x++)
            pix(1'b1, 1'b1, 1'b1, 10'(x), 11'h0A3, 2'd3, COL_WHITE, 1'b1,
                (x == 0 || x == 1 || x == 5) ? 12'hFFF : BG, "fs3_as_1");

        pix(1'b1, 1'b1, 1'b1, 10'd0, 11'h301, 2'd1, COL_WHITE,  1'b0, BG,      "dp_off_lit_bit");
        pix(1'b0, 1'b1, 1'b1, 10'd0, 11'h301, 2'd1, COL_WHITE,  1'b1, 12'h000, "video_off_dp_on");
        pix(1'b0, 1'b1, 1'b1, 10'd1, 11'h301, 2'd1, COL_WHITE,  1'b0, 12'h000, "video_off_unlit");
        pix(1'b1, 1'b1, 1'b1, 10'd0, 11'h301, 2'd1, COL_RED,    1'b1, 12'hF00, "color_red");
        pix(1'b1, 1'b1, 1'b1, 10'd7, 11'h301, 2'd1, COL_YELLOW, 1'b1, 12'hFF0, "color_yellow");
        pix(1'b1, 1'b1, 1'b1, 10'd0, 11'h301, 2'd1, 4'd1,       1'b1, 12'h00F, "color_blue");
        pix(1'b1, 1'b1, 1'b1, 10'd0, 11'h301, 2'd1, COL_BLACK,  1'b1, 12'h000, "color_black");
        pix(1'b1, 1'b0, 1'b1, 10'd1, 11'h301, 2'd1, COL_RED,    1'b1, BG,      "red_unlit_bit");
        idle(2);

        blink_frame(12'hFFF, "blink_f0");
        blink_frame(12'hFFF, "blink_f1");
        blink_frame(BG,      "blink_f2");
        blink_frame(BG,      "blink_f3");
        blink_frame(12'hFFF, "blink_f4");
        blink_frame(12'hFFF, "blink_f5");
        blink_frame(BG,      "blink_f6");

        for (int x = 0; x < 4; x++)
            pix(1'b1, 1'b1, 1'b1, 10'(x), 11'h155, 2'd1, COL_WHITE, 1'b1, 12'hFFF, "run_pre_reset");
        pulse_reset(1);
        for (int x = 4; x < 8; x++)
            pix(1'b1, 1'b1, 1'b1, 10'(x), 11'h155, 2'd1, COL_WHITE, 1'b1, 12'hFFF, "run_post_reset");
        idle(3);
        blink_frame(12'hFFF, "blink_rst_f0");
        blink_frame(12'hFFF, "blink_rst_f1");
        pix(1'b1, 1'b1, 1'b1, 10'd0, 11'h301, 2'd1, COL_BLINK, 1'b1, BG, "blink_rst_f2");
        idle(6);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/text_pixel_renderer.md
Name: text_pixel_renderer

Overview:
- Consumer end of the character overlay path. Takes the per-pixel font ROM address, font size, colour index and display flag from the text overlay generator.
- Fetches the font row from the synchronous font ROM and selects the pixel bit.
- Maps the colour index through a fixed palette and emits registered 12-bit RGB.
- Delays hsync/vsync by the same pipeline depth so sync stays pixel-aligned at the VGA output.

Parameters:
- BG_COLOR, 12'h000, RGB shown where no glyph pixel is lit (dp=0 or font bit 0).
- BLINK_FRAMES, 30, frames per blink half-period for colour index 15.
- PIPE_LAT, 3, fixed input-to-output latency in clocks; documentation only, not overridable.

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- video_on  in  1  active display region flag, aligned with pixelx
- hsync_in  in  1  horizontal sync, aligned with pixelx
- vsync_in  in  1  vertical sync (active-low), aligned with pixelx
- pixelx  in  10  current pixel column
- rom_addr  in  11  {char_addr[6:0], row[3:0]} from overlay generator
- font_size  in  2  1 = 8x16, 2 = 2x horizontal; 0 and 3 treated as 1
- color_addr  in  4  palette index
- dp  in  1  glyph present at this pixel
- font_rom_addr  out  11  address to font ROM (ROM has 1-cycle synchronous read)
- font_rom_data  in  8  ROM row; bit 7 = leftmost column
- hsync_out  out  1  hsync delayed PIPE_LAT clocks
- vsync_out  out  1  vsync delayed PIPE_LAT clocks
- rgb  out  12  {R[3:0],G[3:0],B[3:0]}

Behaviour:
- Stage 1 (edge N+1): register rom_addr into font_rom_addr. Register side-band: column, colour index, dp, video_on, syncs.
- Column rule: font_size 2 uses pixelx[3:1]; every other value uses pixelx[2:0].
- Stage 2 (edge N+2): ROM output valid. Side-band advances one register.
- Stage 3 (edge N+3): rgb is registered.
  - video_on=0 -> rgb = 12'h000, regardless of dp.
  - dp=1 and font_rom_data[7-col]=1 -> rgb = palette[color].
  - Otherwise -> rgb = BG_COLOR.
- Latency: exactly 3 clocks from inputs to rgb/hsync_out/vsync_out. No stalls, no handshake; one pixel accepted per clock.
- Palette: 16 constant entries.
  - 0 = 12'h000, 1 = 12'h00F, 2 = 12'hFFF, 3 = 12'hFF0, 4 = 12'hF00.
  - 5–14 are defined in the package.
  - 15 = blink: 12'hFFF while blink_phase=1, BG_COLOR while blink_phase=0.
- Blink counter:
  - Counts vsync_in falling edges, detected against a registered copy of vsync_in.
  - On reaching BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase.
  - Counter width is clog2(BLINK_FRAMES).
  - A falling edge in the same cycle as reset is ignored.
- blink_phase is sampled at stage 3, so a mid-frame toggle affects only later pixels.
- Reset: all pipeline registers cleared.
  - font_rom_addr = 0, rgb = 0, hsync_out = 1, vsync_out = 1.
  - Blink counter = 0, blink_phase = 1.
  - Reset asserted mid-line: outputs take reset values on the next edge. The first valid rgb appears 3 clocks after reset deasserts. Stale in-flight pixels are discarded, never emitted.
- Sync inputs pass through untouched in polarity; only delayed.

Decomposition:
- Package text_render_pkg holds:
  - PALETTE array (16 x 12-bit)
  - RGB_W = 12, ROM_ADDR_W = 11, FONT_W = 8
  - Named colour indices: COL_BLACK = 0, COL_WHITE = 2, COL_YELLOW = 3, COL_RED = 4, COL_BLINK = 15
- One sub-module, frame_blink_counter: vsync edge detect, frame counter, blink_phase output, parameter BLINK_FRAMES.

Test Plan:
- Reset: hold reset 5 clks with random inputs -> rgb = 0, hsync_out = 1, vsync_out = 1, font_rom_addr = 0 throughout; first non-reset rgb at clock 3 after release.
- Latency/bit order: ROM model returns 8'b1000_0001 for addr 0x301; drive pixelx 0..7, dp = 1, color 2, font_size 1, video_on = 1 -> rgb = FFF at pixels 0 and 7, BG_COLOR elsewhere, each 3 clks after input; hsync_out equals hsync_in delayed 3.
- Scaling: same ROM row, font_size 2, pixelx 0..15 -> rgb = FFF for pixelx 0,1,14,15 only; font_size 0 behaves identically to 1.
- Masking: dp = 0 with lit ROM bit -> BG_COLOR; video_on = 0 with dp = 1 -> 12'h000; colour 4 lit -> 12'hF00.
- Blink: BLINK_FRAMES = 2, colour 15 lit pixel each frame -> rgb = FFF for frames 0–1, BG_COLOR for frames 2–3, FFF for frames 4–5.
- Reset mid-line: assert reset 1 clk during a lit run -> no lit pixel emitted for the 3 output cycles after reset; blink counter restarts at 0.
